// File: rtl/ser_arbiter.sv
// Round-robin scheduler sharing one serializer among N_REQ requesters.
// Grants one request, issues a single-cycle load, then follows the
// serializer busy flag to completion. Bit counts 1 and 2 are rejected
// up front, and a load that never raises busy is abandoned after BUSY_TO
// cycles. Both cases report a drop pulse.
module ser_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 16,
    parameter int MOD_W   = 4,
    parameter int BUSY_TO = 4,
    localparam int IDW    = $clog2(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    input  logic [N_REQ*MOD_W-1:0]  req_mod_i,
    input  logic [N_REQ-1:0]        req_val_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]       ser_data_o,
    output logic [MOD_W-1:0]        ser_data_mod_o,
    output logic                    ser_data_val_o,
    input  logic                    ser_busy_i,
    output logic                    gnt_active_o,
    output logic [IDW-1:0]          gnt_id_o,
    output logic                    drop_o,
    output logic [IDW-1:0]          drop_id_o
);

    localparam int CW = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t              state, state_d;
    logic [IDW-1:0]      ptr, gnt_q, drop_id_q, pick;
    logic [CW-1:0]       cnt;
    logic [DATA_W-1:0]   data_q;
    logic [MOD_W-1:0]    mod_q;
    logic                drop_q;
    logic                found, grant_ok, bad_mod;
    logic                hs, bad_hs, tmo, done;
    logic [IDW:0]        idx;
    logic [DATA_W-1:0]   data_arr [N_REQ];
    logic [MOD_W-1:0]    mod_arr  [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign data_arr[k] = req_data_i[k*DATA_W +: DATA_W];
        assign mod_arr[k]  = req_mod_i[k*MOD_W +: MOD_W];
    end

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == IDW'(N_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    // First valid requester scanning upward from ptr, with wrap-around
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(N_REQ)) idx = idx - (IDW+1)'(N_REQ);
            if (!found && req_val_i[idx[IDW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
    end

    // Ready only in a quiet IDLE cycle; suppressed during reset and drop cycles
    assign grant_ok    = arstn_i && (state == IDLE) && !ser_busy_i && !drop_q && found;
    assign req_ready_o = grant_ok ? (N_REQ'(1) << pick) : '0;
    assign bad_mod     = (mod_arr[pick] == MOD_W'(1)) || (mod_arr[pick] == MOD_W'(2));

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_d = state;
        hs      = 1'b0;
        bad_hs  = 1'b0;
        tmo     = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (grant_ok) begin
                hs      = 1'b1;
                bad_hs  = bad_mod;
                state_d = bad_mod ? IDLE : ISSUE;
            end
            ISSUE: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (ser_busy_i) state_d = WAIT_DONE;
                else if (cnt == CW'(BUSY_TO - 1)) begin
                    state_d = IDLE;
                    tmo     = 1'b1;
                end
            end
            WAIT_DONE: if (!ser_busy_i) begin
                state_d = IDLE;
                done    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) state <= IDLE;
        else          state <= state_d;
    end

    // Holding registers, pointer, timeout counter and drop reporting
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ptr       <= '0;
            gnt_q     <= '0;
            data_q    <= '0;
            mod_q     <= '0;
            cnt       <= '0;
            drop_q    <= 1'b0;
            drop_id_q <= '0;
        end else begin
            drop_q <= bad_hs | tmo;
            if (bad_hs)   drop_id_q <= pick;
            else if (tmo) drop_id_q <= gnt_q;
            if (hs) begin
                gnt_q <= pick;
                // Rejected words never reach the serializer outputs
                if (bad_hs) ptr <= next_id(pick);
                else begin
                    data_q <= data_arr[pick];
                    mod_q  <= mod_arr[pick];
                end
            end
            if (tmo || done) ptr <= next_id(gnt_q);
            if (state == ISSUE)                        cnt <= '0;
            else if (state == WAIT_BUSY && !ser_busy_i) cnt <= cnt + 1'b1;
        end
    end

    assign ser_data_o     = data_q;
    assign ser_data_mod_o = mod_q;
    assign ser_data_val_o = (state == ISSUE);
    assign gnt_active_o   = (state != IDLE);
    assign gnt_id_o       = gnt_q;
    assign drop_o         = drop_q;
    assign drop_id_o      = drop_id_q;

endmodule

// File: tb/tb_ser_arbiter.sv
// Directed bench for ser_arbiter: single load, round-robin order, invalid
// count drop, busy timeout, busy held in IDLE, asynchronous reset mid-transfer.
module tb_ser_arbiter;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic [63:0] req_data;
    logic [15:0] req_mod;
    logic [3:0]  req_val;
    logic [3:0]  req_ready;
    logic [15:0] ser_data;
    logic [3:0]  ser_mod;
    logic        ser_val;
    logic        ser_busy;
    logic        gnt_active;
    logic [1:0]  gnt_id;
    logic        drop;
    logic [1:0]  drop_id;

    int checks = 0;
    int errors = 0;

    ser_arbiter #(.N_REQ(4), .DATA_W(16), .MOD_W(4), .BUSY_TO(4)) dut (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .req_data_i(req_data), .req_mod_i(req_mod), .req_val_i(req_val),
        .req_ready_o(req_ready),
        .ser_data_o(ser_data), .ser_data_mod_o(ser_mod), .ser_data_val_o(ser_val),
        .ser_busy_i(ser_busy),
        .gnt_active_o(gnt_active), .gnt_id_o(gnt_id),
        .drop_o(drop), .drop_id_o(drop_id)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to 2 time units after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic set_req(input int k, input logic v, input logic [15:0] d, input logic [3:0] m);
        req_val[k]         = v;
        req_data[k*16+:16] = d;
        req_mod[k*4+:4]    = m;
    endtask

    // One full transfer starting from an IDLE cycle where requester id should win
    task automatic xfer(input int id, input logic [15:0] d, input logic [3:0] m, input int blen);
        #1;
        chk("xfer_ready", 32'(req_ready), 32'(1) << id);
        tick();
        chk("xfer_val",    32'(ser_val), 32'd1);
        chk("xfer_data",   32'(ser_data), 32'(d));
        chk("xfer_mod",    32'(ser_mod), 32'(m));
        chk("xfer_gnt",    32'(gnt_id), 32'(id));
        chk("xfer_noready", 32'(req_ready), 32'd0);
        chk("xfer_nodrop", 32'(drop), 32'd0);
        tick();
        chk("xfer_val_off", 32'(ser_val), 32'd0);
        chk("xfer_active", 32'(gnt_active), 32'd1);
        ser_busy = 1'b1;
        repeat (blen) begin
            tick();
            chk("busy_active", 32'(gnt_active), 32'd1);
            chk("busy_noready", 32'(req_ready), 32'd0);
            chk("busy_data",   32'(ser_data), 32'(d));
        end
        ser_busy = 1'b0;
        tick();
        chk("done_idle", 32'(gnt_active), 32'd0);
        chk("done_gnt",  32'(gnt_id), 32'(id));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        arstn_i  = 1'b0;
        req_data = '0;
        req_mod  = '0;
        req_val  = '0;
        ser_busy = 1'b0;
        #3;
        chk("rst_ready",  32'(req_ready), 32'd0);
        chk("rst_val",    32'(ser_val), 32'd0);
        chk("rst_data",   32'(ser_data), 32'd0);
        chk("rst_active", 32'(gnt_active), 32'd0);
        chk("rst_gnt",    32'(gnt_id), 32'd0);
        chk("rst_drop",   32'(drop), 32'd0);
        tick();
        arstn_i = 1'b1;

        // 1: single requester load, busy for 6 cycles
        tick();
        set_req(0, 1'b1, 16'hB000, 4'd6);
        xfer(0, 16'hB000, 4'd6, 6);
        req_val = '0;

        // 2: round robin from a fresh pointer, all four valid with mod 0
        arstn_i = 1'b0;
        tick();
        arstn_i = 1'b1;
        for (int k = 0; k < 4; k++) set_req(k, 1'b1, 16'hB005 + 16'(k), 4'd0);
        xfer(0, 16'hB005, 4'd0, 2);
        xfer(1, 16'hB006, 4'd0, 1);
        xfer(2, 16'hB007, 4'd0, 3);
        xfer(3, 16'hB008, 4'd0, 1);
        xfer(0, 16'hB005, 4'd0, 2);

        // 3: invalid count on req1 is dropped, req2 loads next (ptr is 1)
        req_val = '0;
        set_req(1, 1'b1, 16'h1111, 4'd2);
        set_req(2, 1'b1, 16'h2222, 4'd5);
        #1;
        chk("inv_ready", 32'(req_ready), 32'b0010);
        tick();
        req_val[1] = 1'b0;
        #1;
        chk("inv_drop",    32'(drop), 32'd1);
        chk("inv_drop_id", 32'(drop_id), 32'd1);
        chk("inv_noload",  32'(ser_val), 32'd0);
        chk("inv_noready", 32'(req_ready), 32'd0);
        chk("inv_idle",    32'(gnt_active), 32'd0);
        chk("inv_gnt",     32'(gnt_id), 32'd1);
        chk("inv_data",    32'(ser_data), 32'hB005);
        tick();
        chk("inv_drop_end", 32'(drop), 32'd0);
        xfer(2, 16'h2222, 4'd5, 3);
        req_val = '0;

        // 4: busy never rises after req3 load -> 4 cycles in WAIT_BUSY then drop
        set_req(3, 1'b1, 16'h3333, 4'd9);
        #1;
        chk("to_ready", 32'(req_ready), 32'b1000);
        tick();
        chk("to_load", 32'(ser_val), 32'd1);
        req_val = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("to_wait_active", 32'(gnt_active), 32'd1);
            chk("to_wait_nodrop", 32'(drop), 32'd0);
        end
        tick();
        chk("to_drop",    32'(drop), 32'd1);
        chk("to_drop_id", 32'(drop_id), 32'd3);
        chk("to_idle",    32'(gnt_active), 32'd0);
        chk("to_noload",  32'(ser_val), 32'd0);
        tick();

        // 5: busy held high in IDLE blocks grant; ptr 0 picks req0 over req3
        ser_busy = 1'b1;
        set_req(0, 1'b1, 16'h5A5A, 4'd0);
        set_req(3, 1'b1, 16'h3333, 4'd9);
        #1;
        chk("ext_busy_ready0", 32'(req_ready), 32'd0);
        tick();
        chk("ext_busy_ready1", 32'(req_ready), 32'd0);
        chk("ext_busy_idle",   32'(gnt_active), 32'd0);
        ser_busy = 1'b0;
        xfer(0, 16'h5A5A, 4'd0, 2);
        req_val[0] = 1'b0;

        // 6: reset asserted mid-cycle while in WAIT_DONE
        #1;
        chk("ar_ready", 32'(req_ready), 32'b1000);
        tick();
        chk("ar_load", 32'(ser_data), 32'h3333);
        req_val = '0;
        tick();
        ser_busy = 1'b1;
        tick();
        chk("ar_in_transfer", 32'(gnt_active), 32'd1);
        #3;
        arstn_i = 1'b0;
        #1;
        chk("ar_active", 32'(gnt_active), 32'd0);
        chk("ar_data",   32'(ser_data), 32'd0);
        chk("ar_mod",    32'(ser_mod), 32'd0);
        chk("ar_gnt",    32'(gnt_id), 32'd0);
        chk("ar_drop_id", 32'(drop_id), 32'd0);
        chk("ar_val",    32'(ser_val), 32'd0);
        ser_busy = 1'b0;
        tick();
        arstn_i = 1'b1;
        set_req(2, 1'b1, 16'h2C2C, 4'd7);
        set_req(0, 1'b1, 16'h0C0C, 4'd8);
        xfer(0, 16'h0C0C, 4'd8, 1);
        req_val[0] = 1'b0;
        #1;
        chk("ar_next_req2", 32'(req_ready), 32'b0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
